// File: rtl/acia_save_capture_if.sv
// Bus between the ACIA transmit tap / hps_io upload port and the save-capture buffer.
interface acia_save_capture_if #(parameter int ADDR_W = 14);
    logic              arm;
    logic              tx_valid;
    logic [7:0]        tx_data;
    logic              ioctl_upload;
    logic              ioctl_rd;
    logic [15:0]       ioctl_addr;
    logic [7:0]        ioctl_din;
    logic              upload_req;
    logic [ADDR_W:0]   capture_len;
    logic              overflow;
    logic              busy;

    modport master (
        output arm, tx_valid, tx_data, ioctl_upload, ioctl_rd, ioctl_addr,
        input  ioctl_din, upload_req, capture_len, overflow, busy
    );

    modport slave (
        input  arm, tx_valid, tx_data, ioctl_upload, ioctl_rd, ioctl_addr,
        output ioctl_din, upload_req, capture_len, overflow, busy
    );
endinterface

// File: rtl/acia_save_capture.sv
// Captures bytes transmitted by the emulated 6850 ACIA into a RAM buffer and
// serves that buffer to hps_io as a file upload once the transmission goes quiet.
module acia_save_capture #(
    parameter int ADDR_W       = 14,
    parameter int IDLE_TIMEOUT = 48000000
) (
    input  logic               clk_sys,
    input  logic               reset,
    acia_save_capture_if.slave bus
);
    localparam int DEPTH = 2 ** ADDR_W;
    localparam int TMR_W = $clog2(IDLE_TIMEOUT + 1);
    localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(IDLE_TIMEOUT - 1);

    typedef enum logic [1:0] {IDLE, CAPTURE, READY, UPLOAD} state_t;

    state_t            state;
    state_t            next_state;
    logic [ADDR_W:0]   wptr;
    logic [TMR_W-1:0]  timer;
    logic              overflow_r;
    logic [7:0]        din_r;
    logic              upload_q;
    logic              upload_rise;
    logic              upload_fall;
    logic              full;
    logic              wr_en;
    logic [7:0]        mem [DEPTH];

    assign upload_rise = bus.ioctl_upload & ~upload_q;
    assign upload_fall = ~bus.ioctl_upload & upload_q;
    assign full        = wptr[ADDR_W];
    // Bytes arriving on the cycle arm drops are not kept.
    assign wr_en       = (state == CAPTURE) && bus.arm && bus.tx_valid && !full;

    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= next_state;
    end

    always_comb begin
        next_state = state;
        unique case (state)
            IDLE:    if (bus.arm) next_state = CAPTURE;
            CAPTURE: begin
                if (!bus.arm)
                    next_state = (wptr != '0) ? READY : IDLE;
                else if (!bus.tx_valid && wptr != '0 && timer == TMR_LAST)
                    next_state = READY;
            end
            READY: begin
                if (!bus.arm)        next_state = IDLE;
                else if (upload_rise) next_state = UPLOAD;
            end
            UPLOAD:  if (upload_fall) next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    always_comb begin
        bus.upload_req = (state == READY) || (state == UPLOAD);
        bus.busy       = (state == CAPTURE) || (state == UPLOAD);
    end

    // Buffer RAM: contents deliberately not reset.
    always_ff @(posedge clk_sys) begin
        if (wr_en) mem[wptr[ADDR_W-1:0]] <= bus.tx_data;
    end

    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            wptr       <= '0;
            timer      <= '0;
            overflow_r <= 1'b0;
            din_r      <= 8'h00;
            upload_q   <= 1'b0;
        end else begin
            upload_q <= bus.ioctl_upload;
            if (state == IDLE && bus.arm) begin
                wptr       <= '0;
                timer      <= '0;
                overflow_r <= 1'b0;
            end
            if (state == CAPTURE && bus.arm) begin
                if (bus.tx_valid) begin
                    timer <= '0;
                    if (full) overflow_r <= 1'b1;
                    else      wptr <= wptr + (ADDR_W+1)'(1);
                end else if (wptr != '0 && timer != TMR_LAST) begin
                    timer <= timer + TMR_W'(1);
                end
            end
            if (state == UPLOAD && bus.ioctl_rd)
                din_r <= (bus.ioctl_addr < 16'(wptr)) ? mem[bus.ioctl_addr[ADDR_W-1:0]] : 8'h00;
        end
    end

    assign bus.capture_len = wptr;
    assign bus.overflow    = overflow_r;
    assign bus.ioctl_din   = din_r;
endmodule

// File: tb/tb_acia_save_capture.sv
// Directed bench for acia_save_capture with a 16-byte buffer and a short idle timeout.
module tb_acia_save_capture;
    localparam int ADDR_W = 4;
    localparam int T      = 20;

    logic clk = 1'b0;
    logic reset;
    int   checks   = 0;
    int   failures = 0;
    logic [7:0] msg [9];

    acia_save_capture_if #(.ADDR_W(ADDR_W)) bus ();

    acia_save_capture #(.ADDR_W(ADDR_W), .IDLE_TIMEOUT(T)) dut (
        .clk_sys (clk),
        .reset   (reset),
        .bus     (bus.slave)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        repeat (n) tick();
    endtask

    task automatic send(input logic [7:0] b);
        bus.tx_valid = 1'b1;
        bus.tx_data  = b;
        tick();
        bus.tx_valid = 1'b0;
    endtask

    task automatic rd(input logic [15:0] a);
        bus.ioctl_rd   = 1'b1;
        bus.ioctl_addr = a;
        tick();
        bus.ioctl_rd   = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        msg = '{8'h31, 8'h30, 8'h20, 8'h50, 8'h52, 8'h49, 8'h4E, 8'h54, 8'h0D};
        reset = 1'b1;
        bus.arm = 1'b0; bus.tx_valid = 1'b0; bus.tx_data = 8'h00;
        bus.ioctl_upload = 1'b0; bus.ioctl_rd = 1'b0; bus.ioctl_addr = 16'h0;
        #3;
        chk("rst_upload_req", bus.upload_req, 0);
        chk("rst_busy", bus.busy, 0);
        chk("rst_len", bus.capture_len, 0);
        chk("rst_overflow", bus.overflow, 0);
        chk("rst_din", bus.ioctl_din, 0);
        tick();
        reset = 1'b0;
        tick();

        // 1: basic capture and timeout
        bus.arm = 1'b1;
        tick();
        chk("t1_busy", bus.busy, 1);
        for (int i = 0; i < 9; i++) send(msg[i]);
        idle(T - 1);
        chk("t1_pre_timeout_req", bus.upload_req, 0);
        chk("t1_pre_timeout_busy", bus.busy, 1);
        tick();
        chk("t1_upload_req", bus.upload_req, 1);
        chk("t1_busy_ready", bus.busy, 0);
        chk("t1_len", bus.capture_len, 9);
        chk("t1_overflow", bus.overflow, 0);

        // 2: upload readback
        bus.ioctl_upload = 1'b1;
        tick();
        chk("t2_busy", bus.busy, 1);
        chk("t2_req", bus.upload_req, 1);
        for (int a = 0; a < 10; a++) begin
            rd(16'(a));
            chk($sformatf("t2_rd%0d", a), bus.ioctl_din, (a < 9) ? 32'(msg[a]) : 32'h0);
            if (a == 0) begin
                tick();
                chk("t2_hold", bus.ioctl_din, 8'h31);
            end
        end
        bus.arm = 1'b0;
        tick();
        chk("t2_arm_ignored", bus.busy, 1);
        bus.ioctl_upload = 1'b0;
        tick();
        chk("t2_end_req", bus.upload_req, 0);
        chk("t2_end_busy", bus.busy, 0);
        chk("t2_len_kept", bus.capture_len, 9);
        rd(16'h0);
        chk("t2_rd_outside", bus.ioctl_din, 8'h00);

        // 3: overflow
        bus.arm = 1'b1;
        tick();
        chk("t3_len_cleared", bus.capture_len, 0);
        for (int i = 0; i < 20; i++) send(8'(8'h40 + i));
        chk("t3_len", bus.capture_len, 16);
        chk("t3_overflow", bus.overflow, 1);
        idle(T);
        chk("t3_req", bus.upload_req, 1);
        bus.tx_valid = 1'b1; bus.tx_data = 8'hEE;
        tick();
        bus.tx_valid = 1'b0;
        chk("t3_ready_ignores_tx", bus.capture_len, 16);
        bus.ioctl_upload = 1'b1;
        tick();
        rd(16'd0);
        chk("t3_rd0", bus.ioctl_din, 8'h40);
        rd(16'd15);
        chk("t3_rd15", bus.ioctl_din, 8'h4F);
        rd(16'd16);
        chk("t3_rd16", bus.ioctl_din, 8'h00);
        bus.ioctl_upload = 1'b0;
        tick();
        chk("t3_end_busy", bus.busy, 0);

        // 4: byte on the timeout cycle wins
        tick();
        chk("t4_overflow_cleared", bus.overflow, 0);
        send(8'h11);
        send(8'h22);
        idle(T - 1);
        send(8'h55);
        chk("t4_len", bus.capture_len, 3);
        chk("t4_busy", bus.busy, 1);
        chk("t4_req", bus.upload_req, 0);
        idle(T - 1);
        chk("t4_still_capture", bus.busy, 1);
        tick();
        chk("t4_ready", bus.upload_req, 1);

        // 5: abort paths
        bus.arm = 1'b0;
        tick();
        bus.arm = 1'b1;
        tick();
        chk("t5a_capture", bus.busy, 1);
        bus.arm = 1'b0;
        tick();
        chk("t5a_busy", bus.busy, 0);
        chk("t5a_req", bus.upload_req, 0);
        bus.arm = 1'b1;
        tick();
        send(8'h61); send(8'h62); send(8'h63);
        bus.arm = 1'b0;
        tick();
        chk("t5b_req", bus.upload_req, 1);
        chk("t5b_len", bus.capture_len, 3);
        tick();
        chk("t5b_idle", bus.upload_req, 0);

        // 6: async reset during upload
        bus.arm = 1'b1;
        tick();
        send(8'h7A); send(8'h7B);
        idle(T);
        bus.ioctl_upload = 1'b1;
        tick();
        rd(16'd1);
        chk("t6_rd1", bus.ioctl_din, 8'h7B);
        #2 reset = 1'b1;
        #1;
        chk("t6_req", bus.upload_req, 0);
        chk("t6_din", bus.ioctl_din, 0);
        chk("t6_len", bus.capture_len, 0);
        chk("t6_busy", bus.busy, 0);
        bus.ioctl_upload = 1'b0;
        bus.arm = 1'b0;
        tick();
        reset = 1'b0;
        tick();
        chk("t6_after_busy", bus.busy, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
